// File: rtl/regfile_read_arbiter_pkg.sv
// ============================================================================
// Module  : regfile_arb_pkg
// Brief   : Shared constants and helpers for the register-file read arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;

    localparam int REQ_OPA = 0;
    localparam int REQ_OPB = 1;
    localparam int REQ_SHF = 2;
    localparam int REQ_STD = 3;

    // Index of the set bit in a one-hot vector of up to eight bits.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_read_arbiter_if.sv
// ============================================================================
// Module  : regfile_read_arbiter_if
// Brief   : Request/grant and mux-return bundle of the register-file read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic                      stall;
    logic [NUM_REQ-1:0]        grant;
    logic [ADDR_W-1:0]         mux_sel;
    logic [DATA_W-1:0]         mux_y;
    logic [DATA_W-1:0]         rdata;
    logic                      rvalid;
    logic [ID_W-1:0]           rid;

    modport slave (
        input  req, req_addr, stall, mux_y,
        output grant, mux_sel, rdata, rvalid, rid
    );

    modport master (
        output req, req_addr, stall, mux_y,
        input  grant, mux_sel, rdata, rvalid, rid
    );
endinterface

`default_nettype wire

// File: rtl/regfile_read_arbiter_pick.sv
// ============================================================================
// Module  : rr_priority_pick
// Brief   : Combinational round-robin picker starting the search at rr_ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [ID_W-1:0]    rr_ptr_i,
    output logic      [NUM_REQ-1:0] grant_o,
    output logic      [ID_W-1:0]    win_o,
    output logic                    any_o
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_gnt;
    logic [NUM_REQ-1:0] gnt;

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    assign rot     = NUM_REQ'({req_i, req_i} >> rr_ptr_i);
    assign rot_gnt = rot & (~rot + NUM_REQ'(1));
    assign gnt     = NUM_REQ'(({rot_gnt, rot_gnt} << rr_ptr_i) >> NUM_REQ);

    assign grant_o = gnt;
    assign win_o   = ID_W'(onehot_to_idx(8'(gnt)));
    assign any_o   = |req_i;

endmodule

`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
// ============================================================================
// Module  : regfile_read_arbiter
// Brief   : Round-robin sharing of one register-file read mux; returns tagged data.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int ID_W    = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    regfile_read_arbiter_if.slave   arb_bus
);

    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win;
    logic               any;
    logic               xfer;
    logic [ADDR_W-1:0]  mux_sel;

    logic [ID_W-1:0]    rr_ptr_q,  rr_ptr_d;
    logic [DATA_W-1:0]  rdata_q,   rdata_d;
    logic [ID_W-1:0]    rid_q,     rid_d;
    logic               rvalid_q,  rvalid_d;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i    (arb_bus.req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .win_o    (win),
        .any_o    (any)
    );

    // Grant is suppressed combinationally while in reset or stalled.
    assign xfer  = any && !arb_bus.stall && rst_n;
    assign grant = xfer ? pick_grant : '0;

    always_comb begin
        mux_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) mux_sel = arb_bus.req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        rvalid_d = 1'b0;
        if (xfer) begin
            rdata_d  = arb_bus.mux_y;
            rid_d    = win;
            rvalid_d = 1'b1;
            rr_ptr_d = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            rdata_q  <= '0;
            rid_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rdata_q  <= rdata_d;
            rid_q    <= rid_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign arb_bus.grant   = grant;
    assign arb_bus.mux_sel = mux_sel;
    assign arb_bus.rdata   = rdata_q;
    assign arb_bus.rid     = rid_q;
    assign arb_bus.rvalid  = rvalid_q;

endmodule

`default_nettype wire
